// File: rtl/rv32i_dmem_responder.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_responder
//   Slave end of the RV32I load/store path. One request is accepted at a
//   time and answered after WAIT_STATES extra cycles. Stores apply a byte-lane
//   mask to word-organised storage. Loads return the addressed data shifted
//   down to bit 0 and trimmed to the access size (zero-filled, not extended).
//
// Parameters
//   ADDR_WIDTH   word-address bits (2^ADDR_WIDTH words of storage)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      request strobe, sampled only while idle
//   we       1 = store, 0 = load
//   addr     byte address
//   funct3   access size in [1:0] (00 byte, 01 half, 10 word); [2] unused
//   wr_data  store data, already placed in its byte lanes
//   wr_mask  byte-lane write enables {b3,b2,b1,b0}
//   busy     high whenever an access is in flight
//   ack      one-cycle response pulse
//   rd_data  right-aligned load data, valid with ack
//   err      qualifies ack: the access was rejected
// ---------------------------------------------------------------------------
module rv32i_dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  state_t      state, next_state;
  logic [3:0]  cnt, cnt_next;

  // Request captured at acceptance.
  logic [31:0] addr_q;
  logic        we_q;
  size_t       size_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;

  // Registered response.
  logic        ack_next, err_next;
  logic [31:0] rd_next;

  logic [31:0] mem [DEPTH];

  // Request fields as seen by the response logic: the live inputs while idle
  // (needed when WAIT_STATES is 0 and the response is computed on the
  // acceptance edge), the captured copy otherwise.
  logic [31:0] sel_addr;
  logic        sel_we;
  size_t       sel_size;
  logic        access_err;
  logic [31:0] word, shifted, load_data;

  logic        unused_funct3;
  assign unused_funct3 = funct3[2];

  assign busy = (state != S_IDLE);

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_addr = (state == S_IDLE) ? addr : addr_q;
    sel_we   = (state == S_IDLE) ? we : we_q;
    sel_size = (state == S_IDLE) ? size_t'(funct3[1:0]) : size_q;

    access_err = 1'b0;
    unique case (sel_size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = sel_addr[0];
      SZ_WORD: access_err = (sel_addr[1:0] != 2'b00);
      SZ_BAD:  access_err = 1'b1;
    endcase
    if ((sel_addr >> (ADDR_WIDTH + 2)) != 32'd0) access_err = 1'b1;

    word    = mem[sel_addr[ADDR_WIDTH+1:2]];
    shifted = word >> {sel_addr[1:0], 3'b000};
    unique case (sel_size)
      SZ_BYTE: load_data = {24'd0, shifted[7:0]};
      SZ_HALF: load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase

    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            next_state = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            next_state = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) next_state = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    // The response registers are loaded on the edge that enters RESP, so
    // ack/err/rd_data are flop outputs and fall back to 0 on the way out.
    ack_next = 1'b0;
    err_next = 1'b0;
    rd_next  = 32'd0;
    if (next_state == S_RESP) begin
      ack_next = 1'b1;
      err_next = access_err;
      rd_next  = (access_err || sel_we) ? 32'd0 : load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      data_q  <= 32'd0;
      mask_q  <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rd_data <= 32'd0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      ack     <= ack_next;
      err     <= err_next;
      rd_data <= rd_next;
      if (state == S_IDLE && req) begin
        addr_q <= addr;
        we_q   <= we;
        size_q <= size_t'(funct3[1:0]);
        data_q <= wr_data;
        mask_q <= wr_mask;
      end
    end
  end

  // NOTE: storage has no reset; contents are undefined until written. The
  // write still honours rst so an access aborted on its RESP edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_dmem_responder
//   Directed bench for rv32i_dmem_responder. One instance runs with one wait
//   state, a second with none. Expected responses are queued when a request
//   is driven and popped when ack is observed.
// ---------------------------------------------------------------------------
module tb_rv32i_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with one wait state.
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wr_data = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [3:0]  wr_mask = 4'd0;
  logic        busy, ack, err;
  logic [31:0] rd_data;

  // Instance with zero wait states.
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wr_data0 = 32'd0;
  logic [2:0]  funct30 = 3'd0;
  logic [3:0]  wr_mask0 = 4'd0;
  logic        busy0, ack0, err0;
  logic [31:0] rd_data0;

  rv32i_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .funct3(funct3),
    .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy), .ack(ack),
    .rd_data(rd_data), .err(err)
  );

  rv32i_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .funct3(funct30),
    .wr_data(wr_data0), .wr_mask(wr_mask0), .busy(busy0), .ack(ack0),
    .rd_data(rd_data0), .err(err0)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] rd, input logic e);
    exp_t x;
    x.tag = tag;
    x.rd  = rd;
    x.err = e;
    sb.push_back(x);
  endtask

  // Compare one observed response against the oldest queued expectation.
  task automatic expect_pop(input logic [31:0] obs_rd, input logic obs_err);
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check({x.tag, " rd_data"}, obs_rd, x.rd);
      check({x.tag, " err"}, {31'd0, obs_err}, {31'd0, x.err});
    end
  endtask

  // Full access on the one-wait-state instance, with latency and
  // post-ack checks.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, " idle before"}, {31'd0, busy}, 32'd0);
    we = w; addr = a; funct3 = f3; wr_data = d; wr_mask = m; req = 1'b1;
    expect_push(tag, exp_rd, exp_err);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack !== 1'b1 && lat < 20);
    req = 1'b0;
    check({tag, " latency"}, lat, 32'd2);
    check({tag, " busy at ack"}, {31'd0, busy}, 32'd1);
    expect_pop(rd_data, err);
    @(negedge clk);
    check({tag, " ack after"}, {31'd0, ack}, 32'd0);
    check({tag, " err after"}, {31'd0, err}, 32'd0);
    check({tag, " rd after"}, rd_data, 32'd0);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset busy0", {31'd0, busy0}, 32'd0);

    // Zero wait states, request held continuously: busy/ack alternate.
    we0 = 1'b1; addr0 = 32'h40; funct30 = 3'b010; wr_data0 = 32'h1234_5678;
    wr_mask0 = 4'hf; req0 = 1'b1; rst = 1'b0;
    #1;
    check("zw busy k0", {31'd0, busy0}, 32'd0);
    check("zw ack k0", {31'd0, ack0}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("zw busy k%0d", k), {31'd0, busy0}, {31'd0, k[0]});
      check($sformatf("zw ack k%0d", k), {31'd0, ack0}, {31'd0, k[0]});
    end
    req0 = 1'b0;
    @(negedge clk);
    we0 = 1'b0; req0 = 1'b1;
    expect_push("zw load 0x40", 32'h1234_5678, 1'b0);
    @(negedge clk);
    req0 = 1'b0;
    check("zw load ack", {31'd0, ack0}, 32'd1);
    expect_pop(rd_data0, err0);

    // Word round trip and byte lanes.
    access("store word 0x10", 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 4'hf, 32'd0, 1'b0);
    access("load word 0x10", 1'b0, 32'h10, 3'b010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    access("store byte 0x12", 1'b1, 32'h12, 3'b000, 32'h00A5_0000, 4'h4, 32'd0, 1'b0);
    access("load word lanes", 1'b0, 32'h10, 3'b010, 32'hFFFF_FFFF, 4'hf, 32'hDEA5_BEEF, 1'b0);
    access("load byte 0x12", 1'b0, 32'h12, 3'b100, 32'd0, 4'h0, 32'h0000_00A5, 1'b0);
    access("load half 0x12", 1'b0, 32'h12, 3'b001, 32'd0, 4'h0, 32'h0000_DEA5, 1'b0);
    access("load byte 0x13", 1'b0, 32'h13, 3'b000, 32'd0, 4'h0, 32'h0000_00DE, 1'b0);

    // Zero mask writes nothing but still acks.
    access("store mask0", 1'b1, 32'h10, 3'b010, 32'h0000_0000, 4'h0, 32'd0, 1'b0);
    access("load after mask0", 1'b0, 32'h10, 3'b010, 32'd0, 4'h0, 32'hDEA5_BEEF, 1'b0);

    // Errors.
    access("half load 0x11", 1'b0, 32'h11, 3'b001, 32'd0, 4'h0, 32'd0, 1'b1);
    access("word store 0x12", 1'b1, 32'h12, 3'b010, 32'h5555_5555, 4'hf, 32'd0, 1'b1);
    access("load after err store", 1'b0, 32'h10, 3'b010, 32'd0, 4'h0, 32'hDEA5_BEEF, 1'b0);
    access("load out of range", 1'b0, 32'h0000_1000, 3'b010, 32'd0, 4'h0, 32'd0, 1'b1);
    access("size 11", 1'b0, 32'h10, 3'b011, 32'd0, 4'h0, 32'd0, 1'b1);

    // Request changed while busy is ignored.
    @(negedge clk);
    we = 1'b0; addr = 32'h10; funct3 = 3'b010; req = 1'b1;
    expect_push("busy ignore", 32'hDEA5_BEEF, 1'b0);
    @(negedge clk);
    check("busy ignore in wait", {31'd0, busy}, 32'd1);
    check("busy ignore no early ack", {31'd0, ack}, 32'd0);
    we = 1'b1; addr = 32'h80; wr_data = 32'd0; wr_mask = 4'hf;
    @(negedge clk);
    req = 1'b0;
    check("busy ignore ack", {31'd0, ack}, 32'd1);
    expect_pop(rd_data, err);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("busy ignore no extra ack %0d", k), {31'd0, ack}, 32'd0);
    end

    // Reset on the RESP cycle of a store aborts the write.
    access("store 0x20 init", 1'b1, 32'h20, 3'b010, 32'h1111_1111, 4'hf, 32'd0, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; funct3 = 3'b010; wr_data = 32'h2222_2222; wr_mask = 4'hf;
    req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort resp ack", {31'd0, ack}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("abort ack low", {31'd0, ack}, 32'd0);
    check("abort busy low", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    access("load 0x20 after abort", 1'b0, 32'h20, 3'b010, 32'd0, 4'h0, 32'h1111_1111, 1'b0);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
